ppu_hazard_pipeline: RTL and testbench

//  Parametrised PPU control-word pipeline: carries decoded CU control words ID->EX->MEM->WB.

---
 rtl/ppu_hazard_pipeline.sv | 112 +++++++++++
 tb/tb_ppu_hazard_pipeline.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_hazard_pipeline.sv
// Control-word pipeline ID->EX->MEM->WB with load-use stall, jump flush and stall/flush counters.
// Optional PPU_NOFWD_STALL_EN: no-forwarding mode, stalls on any RAW against stages 0..DEPTH-2.
module ppu_hazard_pipeline #(
  parameter int CW    = 32,
  parameter int DEPTH = 3,
  parameter int REGW  = 5,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  id_valid,
  input  logic [CW-1:0]         id_ctrl,
  input  logic [REGW-1:0]       id_rs1,
  input  logic [REGW-1:0]       id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REGW-1:0]       id_rd,
  input  logic                  id_rf_en,
  input  logic                  id_load,
  input  logic                  ex_jump,
  output logic                  pc_le,
  output logic                  ifid_le,
  output logic                  ifid_flush,
  output logic                  nop_sel,
  output logic [DEPTH-1:0]      stage_valid,
  output logic [DEPTH*CW-1:0]   stage_ctrl,
  output logic [CNTW-1:0]       stall_cnt,
  output logic [CNTW-1:0]       flush_cnt
);

  logic [CW-1:0]   ctrl_q  [DEPTH];
  logic [REGW-1:0] rd_q    [DEPTH];
  logic            rf_en_q [DEPTH];
  logic            load_q  [DEPTH];
  logic            valid_q [DEPTH];

  logic hazard;
  logic stall;
  logic flush;

  // True when the ID instruction reads a nonzero register equal to rd.
  function automatic logic id_reads(input logic [REGW-1:0] rd);
    return (rd != '0) &&
           ((id_rs1_used && (id_rs1 == rd)) || (id_rs2_used && (id_rs2 == rd)));
  endfunction

  always_comb begin
    hazard = 1'b0;
`ifdef PPU_NOFWD_STALL_EN
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (valid_q[k] && rf_en_q[k] && id_reads(rd_q[k])) hazard = 1'b1;
    end
`else
    hazard = valid_q[0] && rf_en_q[0] && load_q[0] && id_reads(rd_q[0]);
`endif
    hazard = hazard && id_valid;
  end

  // A jump kills the ID instruction, so any hazard it carries is moot.
  assign flush = ex_jump && !Reset;
  assign stall = hazard && !ex_jump && !Reset;

  always_comb begin
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    ifid_flush = 1'b0;
    nop_sel    = 1'b0;
    if (Reset || flush) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
    end else if (stall) begin
      pc_le   = 1'b0;
      ifid_le = 1'b0;
      nop_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        rd_q[k]    <= '0;
        rf_en_q[k] <= 1'b0;
        load_q[k]  <= 1'b0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        rf_en_q[k] <= rf_en_q[k-1];
        load_q[k]  <= load_q[k-1];
      end
      valid_q[0] <= id_valid && !nop_sel;
      ctrl_q[0]  <= nop_sel ? '0 : id_ctrl;
      rd_q[0]    <= nop_sel ? '0 : id_rd;
      rf_en_q[0] <= id_rf_en && !nop_sel;
      load_q[0]  <= id_load && !nop_sel;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign stage_valid[g]         = valid_q[g];
    assign stage_ctrl[g*CW +: CW] = ctrl_q[g];
  end

endmodule

// File: tb/tb_ppu_hazard_pipeline.sv
// Directed bench for ppu_hazard_pipeline; a second narrow-counter instance covers saturation.
// Expectations follow PPU_NOFWD_STALL_EN when the bench is built with that macro.
module tb_ppu_hazard_pipeline;

`ifdef PPU_NOFWD_STALL_EN
  localparam bit NOFWD = 1'b1;
`else
  localparam bit NOFWD = 1'b0;
`endif

  logic        clk;
  logic        Reset;
  logic        id_valid;
  logic [31:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rf_en, id_load, ex_jump;
  logic        pc_le, ifid_le, ifid_flush, nop_sel;
  logic [2:0]  stage_valid;
  logic [95:0] stage_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_le, s_ifid_le, s_ifid_flush, s_nop_sel;
  logic [2:0]  s_stage_valid;
  logic [95:0] s_stage_ctrl;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  ppu_hazard_pipeline dut (
    .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load), .ex_jump(ex_jump),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush), .nop_sel(nop_sel),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ppu_hazard_pipeline #(.CNTW(2)) u_sat (
    .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load), .ex_jump(ex_jump),
    .pc_le(s_pc_le), .ifid_le(s_ifid_le), .ifid_flush(s_ifid_flush), .nop_sel(s_nop_sel),
    .stage_valid(s_stage_valid), .stage_ctrl(s_stage_ctrl),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic set_id(input logic v, input logic [31:0] c,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] d, input logic we, input logic ld);
    id_valid = v; id_ctrl = c;
    id_rs1 = r1; id_rs1_used = u1;
    id_rs2 = r2; id_rs2_used = u2;
    id_rd = d; id_rf_en = we; id_load = ld;
    #1;
  endtask

  task automatic idle();
    ex_jump = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    // T1: reset held two cycles with a valid ID instruction
    Reset = 1'b1;
    ex_jump = 1'b0;
    set_id(1'b1, 32'hAAAA_0000, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    tick();
    check("rst_valid", 64'(stage_valid), 64'h0);
    check("rst_ctrl", 64'(stage_ctrl[63:0]), 64'h0);
    check("rst_nop_sel", 64'(nop_sel), 64'h1);
    check("rst_flush", 64'(ifid_flush), 64'h1);
    check("rst_pc_le", 64'(pc_le), 64'h1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    Reset = 1'b0;
    idle();
    check("idle_nop_sel", 64'(nop_sel), 64'h0);

    // T2: load x5 into EX, then reader of x5 stalls one cycle
    set_id(1'b1, 32'h1111_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    check("t2_no_stall", 64'(pc_le), 64'h1);
    tick();
    check("t2_ex_valid", 64'(stage_valid), 64'b001);
    check("t2_ex_ctrl", 64'(stage_ctrl[31:0]), 64'h1111_0001);
    set_id(1'b1, 32'h2222_0002, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    check("t2_pc_le", 64'(pc_le), 64'h0);
    check("t2_ifid_le", 64'(ifid_le), 64'h0);
    check("t2_nop_sel", 64'(nop_sel), 64'h1);
    check("t2_ifid_flush", 64'(ifid_flush), 64'h0);
    tick();
    exp_stall++;
    check("t2_bubble_valid", 64'(stage_valid), 64'b010);
    check("t2_bubble_ctrl", 64'(stage_ctrl[31:0]), 64'h0);
    check("t2_mem_ctrl", 64'(stage_ctrl[63:32]), 64'h1111_0001);
    check("t2_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    // ID re-presented; only no-forwarding mode stalls again (producer in MEM)
    check("t2_replay_pc_le", 64'(pc_le), NOFWD ? 64'h0 : 64'h1);
    tick();
    if (NOFWD) exp_stall++;
    check("t2_replay_valid", 64'(stage_valid), NOFWD ? 64'b100 : 64'b101);
    check("t2_replay_ctrl", 64'(stage_ctrl[31:0]), NOFWD ? 64'h0 : 64'h2222_0002);
    check("t2_replay_cnt", 64'(stall_cnt), 64'(exp_stall));
    drain();
    check("t2_drained", 64'(stage_valid), 64'b000);

    // T3: load to x0 never stalls
    set_id(1'b1, 32'h3333_0003, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h3333_0004, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    check("t3_pc_le", 64'(pc_le), 64'h1);
    check("t3_nop_sel", 64'(nop_sel), 64'h0);
    tick();
    check("t3_valid", 64'(stage_valid), 64'b011);
    check("t3_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    drain();

    // rs2 path, unused-source match, invalid ID, non-load producer
    set_id(1'b1, 32'h4444_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h4444_0002, 5'd1, 1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 1'b0);
    check("rs2_stall", 64'(pc_le), 64'h0);
    set_id(1'b1, 32'h4444_0002, 5'd9, 1'b0, 5'd9, 1'b0, 5'd2, 1'b1, 1'b0);
    check("unused_src_no_stall", 64'(pc_le), 64'h1);
    set_id(1'b0, 32'h4444_0002, 5'd9, 1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 1'b0);
    check("invalid_id_no_stall", 64'(pc_le), 64'h1);
    tick();
    check("invalid_id_bubble", 64'(stage_valid), 64'b010);
    drain();

    // Latency: ID word reaches stage k after k+1 edges
    set_id(1'b1, 32'h5555_0005, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    check("lat_ex", 64'(stage_ctrl[31:0]), 64'h5555_0005);
    tick();
    check("lat_mem", 64'(stage_ctrl[63:32]), 64'h5555_0005);
    tick();
    check("lat_wb", 64'(stage_ctrl[95:64]), 64'h5555_0005);
    check("lat_wb_valid", 64'(stage_valid), 64'b100);
    tick();

    // T4: jump with a simultaneous load-use hazard -> flush wins
    set_id(1'b1, 32'h6666_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h6666_0002, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_jump = 1'b1;
    #1;
    check("t4_ifid_flush", 64'(ifid_flush), 64'h1);
    check("t4_pc_le", 64'(pc_le), 64'h1);
    check("t4_ifid_le", 64'(ifid_le), 64'h1);
    check("t4_nop_sel", 64'(nop_sel), 64'h1);
    tick();
    exp_flush++;
    check("t4_valid", 64'(stage_valid), 64'b010);
    check("t4_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("t4_flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    drain();

    // T6: non-load producer x3 in EX, reader of x3 on rs2
    set_id(1'b1, 32'h7777_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 32'h7777_0002, 5'd0, 1'b0, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_pc_le_%0d", i), 64'(pc_le), (NOFWD && i < 2) ? 64'h0 : 64'h1);
      tick();
      if (NOFWD && i < 2) exp_stall++;
    end
    check("t6_valid", 64'(stage_valid), NOFWD ? 64'b001 : 64'b111);
    check("t6_ex_ctrl", 64'(stage_ctrl[31:0]), 64'h7777_0002);
    check("t6_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    drain();

    // T5: saturation on the 2-bit counter instance
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 32'h8888_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 32'h8888_0002, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      tick();
      exp_stall++;
    end
    idle();
    ex_jump = 1'b1;
    #1;
    repeat (4) begin
      tick();
      exp_flush++;
    end
    idle();
    check("sat_main_stall", 64'(stall_cnt), 64'(exp_stall));
    check("sat_main_flush", 64'(flush_cnt), 64'(exp_flush));
    check("sat_stall", 64'(s_stall_cnt), 64'(exp_stall > 3 ? 3 : exp_stall));
    check("sat_flush", 64'(s_flush_cnt), 64'(exp_flush > 3 ? 3 : exp_flush));
    tick();
    check("sat_hold", 64'(s_flush_cnt), 64'h3);

    // Reset in the middle of a stall clears everything
    set_id(1'b1, 32'h9999_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h9999_0002, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    check("mid_stall", 64'(pc_le), 64'h0);
    Reset = 1'b1;
    #1;
    check("mid_rst_pc_le", 64'(pc_le), 64'h1);
    tick();
    Reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check("mid_rst_valid", 64'(stage_valid), 64'b000);
    check("mid_rst_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("mid_rst_flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    check("mid_rst_no_pending", 64'(pc_le), 64'h1);
    tick();
    check("mid_rst_advance", 64'(stage_ctrl[31:0]), 64'h9999_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
